// File: rtl/inst_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : inst_mem_ctrl_pkg
// Brief   : Shared defaults and state encoding for the instruction memory.
// Revision: 1.0 - initial release
// ============================================================================
package inst_mem_ctrl_pkg;

  localparam int DEFAULT_INSTRUCTION_MEM_SIZE = 8192;
  localparam int DEFAULT_INSTRUCTION_WIDTH    = 18;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  typedef enum logic [0:0] {
    STATE_RUN  = ST_RUN,
    STATE_LOAD = ST_LOAD
  } state_e;

endpackage
`default_nettype wire

// File: rtl/inst_mem_ctrl_array.sv
`default_nettype none
// ============================================================================
// Module  : inst_mem_array
// Brief   : Simple dual-port RAM, one write port and one registered read port.
// Revision: 1.0 - initial release
// ============================================================================
module inst_mem_array #(
  parameter int DEPTH      = 8192,
  parameter int WIDTH      = 18,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  // No reset on the array or its read register so it maps onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      rd_data_q <= mem[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/inst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : inst_mem_ctrl
// Brief   : Instruction memory with sequential load port, valid/ready fetch
//           port, 1- or 2-cycle read latency, stall and range checking.
// Revision: 1.0 - initial release
// ============================================================================
module inst_mem_ctrl
  import inst_mem_ctrl_pkg::*;
#(
  parameter int INSTRUCTION_MEM_SIZE   = DEFAULT_INSTRUCTION_MEM_SIZE,
  parameter int INSTRUCTION_WIDTH      = DEFAULT_INSTRUCTION_WIDTH,
  parameter int INSTRUCTION_ADDR_WIDTH = $clog2(INSTRUCTION_MEM_SIZE),
  parameter int READ_LATENCY           = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_load_en,
  input  logic                              i_load_valid,
  input  logic [INSTRUCTION_WIDTH-1:0]      i_load_data,
  output logic                              o_load_ready,
  output logic [INSTRUCTION_ADDR_WIDTH:0]   o_load_count,
  output logic                              o_load_full,
  input  logic                              i_fetch_valid,
  input  logic [INSTRUCTION_ADDR_WIDTH-1:0] i_fetch_addr,
  output logic                              o_fetch_ready,
  input  logic                              i_stall,
  output logic                              o_instr_valid,
  output logic [INSTRUCTION_WIDTH-1:0]      o_instruction,
  output logic                              o_addr_err
);

  localparam int             CW         = INSTRUCTION_ADDR_WIDTH + 1;
  localparam logic [CW-1:0]  C_MEM_SIZE = CW'(INSTRUCTION_MEM_SIZE);

  state_e                 state_q, state_d;
  logic [CW-1:0]          load_count_q, load_count_d;
  logic                   v1_q, v1_d;
  logic                   err1_q, err1_d;

  logic                   w_load_write;
  logic                   w_fetch_accept;
  logic                   w_addr_oor;
  logic [INSTRUCTION_WIDTH-1:0] w_rd_data;
  logic [INSTRUCTION_WIDTH-1:0] w_s1_data;

  assign o_fetch_ready  = (state_q == STATE_RUN) && !i_load_en && !i_stall;
  assign o_load_full    = (load_count_q == C_MEM_SIZE);
  assign o_load_ready   = (state_q == STATE_LOAD) && !o_load_full;
  assign o_load_count   = load_count_q;

  assign w_load_write   = i_load_valid && o_load_ready && !i_rst;
  assign w_fetch_accept = i_fetch_valid && o_fetch_ready;
  assign w_addr_oor     = ({1'b0, i_fetch_addr} >= C_MEM_SIZE);

  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    v1_d         = v1_q;
    err1_d       = err1_q;

    case (state_q)
      STATE_RUN: begin
        if (i_load_en) begin
          state_d      = STATE_LOAD;
          load_count_d = '0;
        end
      end
      STATE_LOAD: begin
        if (w_load_write) begin
          load_count_d = load_count_q + CW'(1);
        end
        if (!i_load_en) begin
          state_d = STATE_RUN;
        end
      end
      default: state_d = STATE_RUN;
    endcase

    // Stage 1 advances only when not stalled; a stalled stage keeps its word.
    if (!i_stall) begin
      v1_d = w_fetch_accept;
      if (w_fetch_accept) begin
        err1_d = w_addr_oor;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= STATE_RUN;
      load_count_q <= '0;
      v1_q         <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      v1_q         <= v1_d;
      err1_q       <= err1_d;
    end
  end

  inst_mem_array #(
    .DEPTH      (INSTRUCTION_MEM_SIZE),
    .WIDTH      (INSTRUCTION_WIDTH),
    .ADDR_WIDTH (INSTRUCTION_ADDR_WIDTH)
  ) u_array (
    .i_clk     (i_clk),
    .i_wr_en   (w_load_write),
    .i_wr_addr (load_count_q[INSTRUCTION_ADDR_WIDTH-1:0]),
    .i_wr_data (i_load_data),
    .i_rd_en   (w_fetch_accept && !w_addr_oor),
    .i_rd_addr (i_fetch_addr),
    .o_rd_data (w_rd_data)
  );

  assign w_s1_data = err1_q ? '0 : w_rd_data;

  if (READ_LATENCY == 1) begin : g_lat1
    // The RAM read register has no reset; mask it until a fetch has landed.
    logic data_ok_q, data_ok_d;

    always_comb begin
      data_ok_d = data_ok_q | w_fetch_accept;
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        data_ok_q <= 1'b0;
      end else begin
        data_ok_q <= data_ok_d;
      end
    end

    assign o_instr_valid = v1_q;
    assign o_instruction = data_ok_q ? w_s1_data : '0;
    assign o_addr_err    = v1_q & err1_q;
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic                         out_v_q, out_v_d;
    logic                         out_err_q, out_err_d;
    logic [INSTRUCTION_WIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
      out_v_d    = out_v_q;
      out_err_d  = out_err_q;
      out_data_d = out_data_q;
      if (!i_stall) begin
        out_v_d = v1_q;
        if (v1_q) begin
          out_err_d  = err1_q;
          out_data_d = w_s1_data;
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        out_v_q    <= 1'b0;
        out_err_q  <= 1'b0;
        out_data_q <= '0;
      end else begin
        out_v_q    <= out_v_d;
        out_err_q  <= out_err_d;
        out_data_q <= out_data_d;
      end
    end

    assign o_instr_valid = out_v_q;
    assign o_instruction = out_data_q;
    assign o_addr_err    = out_v_q & out_err_q;
  end else begin : g_bad_latency
    $error("inst_mem_ctrl: READ_LATENCY must be 1 or 2");
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_mem_ctrl
// Brief   : Self-checking bench driving latency-1 and latency-2 instances with
//           shared stimulus against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_inst_mem_ctrl;

  localparam int SIZE = 10;
  localparam int W    = 18;
  localparam int AW   = 4;

  typedef struct packed {
    logic         v;
    logic         e;
    logic [W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, load_en, load_valid, fetch_valid, stall;
  logic [W-1:0]  load_data;
  logic [AW-1:0] fetch_addr;

  logic          l1_load_ready, l1_load_full, l1_fetch_ready, l1_valid, l1_err;
  logic [AW:0]   l1_count;
  logic [W-1:0]  l1_instr;
  logic          l2_load_ready, l2_load_full, l2_fetch_ready, l2_valid, l2_err;
  logic [AW:0]   l2_count;
  logic [W-1:0]  l2_instr;

  inst_mem_ctrl #(
    .INSTRUCTION_MEM_SIZE(SIZE), .INSTRUCTION_WIDTH(W),
    .INSTRUCTION_ADDR_WIDTH(AW), .READ_LATENCY(1)
  ) u_dut_lat1 (
    .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_load_valid(load_valid),
    .i_load_data(load_data), .o_load_ready(l1_load_ready), .o_load_count(l1_count),
    .o_load_full(l1_load_full), .i_fetch_valid(fetch_valid), .i_fetch_addr(fetch_addr),
    .o_fetch_ready(l1_fetch_ready), .i_stall(stall), .o_instr_valid(l1_valid),
    .o_instruction(l1_instr), .o_addr_err(l1_err)
  );

  inst_mem_ctrl #(
    .INSTRUCTION_MEM_SIZE(SIZE), .INSTRUCTION_WIDTH(W),
    .INSTRUCTION_ADDR_WIDTH(AW), .READ_LATENCY(2)
  ) u_dut_lat2 (
    .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_load_valid(load_valid),
    .i_load_data(load_data), .o_load_ready(l2_load_ready), .o_load_count(l2_count),
    .o_load_full(l2_load_full), .i_fetch_valid(fetch_valid), .i_fetch_addr(fetch_addr),
    .o_fetch_ready(l2_fetch_ready), .i_stall(stall), .o_instr_valid(l2_valid),
    .o_instruction(l2_instr), .o_addr_err(l2_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: mode flag, word count, memory image and a two-deep
  // history of fetch slots that advances once per non-stalled cycle.
  bit           m_init = 1'b0;
  bit           m_load;
  int           m_count;
  logic [W-1:0] m_mem [SIZE];
  ent_t         m_hist [2];
  logic [W-1:0] m_last [2];
  bit           m_fr, m_lr;
  ent_t         m_new;

  always @(posedge clk) begin
    if (rst) begin
      m_init    = 1'b1;
      m_load    = 1'b0;
      m_count   = 0;
      m_hist[0] = '0;
      m_hist[1] = '0;
      m_last[0] = '0;
      m_last[1] = '0;
    end else if (m_init) begin
      m_fr = !m_load && !load_en && !stall;
      m_lr = m_load && (m_count < SIZE);
      if (m_lr && load_valid) begin
        m_mem[m_count] = load_data;
        m_count++;
      end
      if (!stall) begin
        m_new = '0;
        if (m_fr && fetch_valid) begin
          m_new.v = 1'b1;
          if (int'(fetch_addr) < SIZE) m_new.d = m_mem[fetch_addr];
          else                         m_new.e = 1'b1;
        end
        m_hist[1] = m_hist[0];
        m_hist[0] = m_new;
        if (m_hist[0].v) m_last[0] = m_hist[0].d;
        if (m_hist[1].v) m_last[1] = m_hist[1].d;
      end
      if (!m_load && load_en) begin
        m_load  = 1'b1;
        m_count = 0;
      end else if (m_load && !load_en) begin
        m_load = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("l1_fetch_ready", l1_fetch_ready, !m_load && !load_en && !stall);
      chk("l2_fetch_ready", l2_fetch_ready, !m_load && !load_en && !stall);
      chk("l1_load_ready", l1_load_ready, m_load && (m_count < SIZE));
      chk("l2_load_ready", l2_load_ready, m_load && (m_count < SIZE));
      chk("l1_load_count", l1_count, m_count);
      chk("l2_load_count", l2_count, m_count);
      chk("l1_load_full", l1_load_full, m_count == SIZE);
      chk("l2_load_full", l2_load_full, m_count == SIZE);
      chk("l1_instr_valid", l1_valid, m_hist[0].v);
      chk("l2_instr_valid", l2_valid, m_hist[1].v);
      chk("l1_instruction", l1_instr, m_last[0]);
      chk("l2_instruction", l2_instr, m_last[1]);
      chk("l1_addr_err", l1_err, m_hist[0].v & m_hist[0].e);
      chk("l2_addr_err", l2_err, m_hist[1].v & m_hist[1].e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] words [6];

  initial begin
    words[0] = 18'h00001; words[1] = 18'h3FFFF; words[2] = 18'h12345;
    words[3] = 18'h2AAAA; words[4] = 18'h15555; words[5] = 18'h00000;
    rst = 1'b1; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
    fetch_valid = 1'b0; fetch_addr = '0; stall = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_l1_valid", l1_valid, 0);
    chk("rst_l2_valid", l2_valid, 0);
    chk("rst_l1_instr", l1_instr, 0);
    chk("rst_count", l1_count, 0);
    chk("rst_full", l1_load_full, 0);

    // Load six words, then read them back-to-back.
    load_en = 1'b1;
    step();
    load_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load_data = words[i];
      step();
    end
    load_valid = 1'b0;
    chk("load6_count", l1_count, 6);
    load_en = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      fetch_valid = 1'b1;
      fetch_addr  = AW'(i);
      step();
      chk("read_l1_valid", l1_valid, 1);
      chk("read_l1_data", l1_instr, words[i]);
      if (i > 0) chk("read_l2_data", l2_instr, words[i-1]);
    end
    fetch_valid = 1'b0;
    step();
    chk("read_l2_last", l2_instr, 18'h00000);
    chk("read_l2_valid", l2_valid, 1);
    chk("read_l1_drop", l1_valid, 0);

    // Fill to capacity with two surplus words.
    load_en = 1'b1;
    step();
    load_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      load_data = W'(32'h100 + i);
      step();
    end
    chk("full_count", l1_count, 10);
    chk("full_flag", l1_load_full, 1);
    chk("full_ready", l1_load_ready, 0);
    load_valid = 1'b0;
    load_en    = 1'b0;
    step();

    // Last valid address and two out-of-range ones.
    fetch_valid = 1'b1;
    fetch_addr  = 4'd9;
    step();
    chk("range9_data", l1_instr, 18'h00109);
    chk("range9_err", l1_err, 0);
    fetch_addr = 4'd10;
    step();
    chk("range10_data", l1_instr, 0);
    chk("range10_err", l1_err, 1);
    fetch_addr = 4'd15;
    step();
    chk("range15_data", l1_instr, 0);
    chk("range15_err", l1_err, 1);
    fetch_valid = 1'b0;
    step();

    // Stall holding a delivered word.
    fetch_valid = 1'b1;
    fetch_addr  = 4'd2;
    step();
    chk("stall_pre", l1_instr, 18'h00102);
    fetch_addr = 4'd3;
    stall      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", l1_valid, 1);
      chk("stall_data", l1_instr, 18'h00102);
      chk("stall_ready", l1_fetch_ready, 0);
    end
    stall = 1'b0;
    step();
    chk("stall_resume", l1_instr, 18'h00103);

    // Reset in the middle of a fetch stream.
    fetch_addr = 4'd4;
    step();
    rst = 1'b1;
    step();
    chk("midrst_l1_valid", l1_valid, 0);
    chk("midrst_l2_valid", l2_valid, 0);
    rst = 1'b0;
    step();
    chk("midrst_mem_kept", l1_instr, 18'h00104);

    // Entering LOAD with a word in flight.
    fetch_addr = 4'd5;
    step();
    load_en    = 1'b1;
    fetch_addr = 4'd6;
    #1;
    chk("loaden_ready", l1_fetch_ready, 0);
    step();
    chk("loaden_l2_valid", l2_valid, 1);
    chk("loaden_l2_data", l2_instr, 18'h00105);
    chk("loaden_l1_drop", l1_valid, 0);
    fetch_valid = 1'b0;
    load_en     = 1'b0;
    step(); step();

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) load_en = ~load_en;
      load_valid  = ($urandom_range(0, 1) == 1);
      load_data   = W'($urandom);
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_addr  = AW'($urandom_range(0, 15));
      stall       = ($urandom_range(0, 4) == 0);
      step();
    end
    rst = 1'b0; load_en = 1'b0; load_valid = 1'b0; fetch_valid = 1'b0; stall = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
